// File: rtl/rib_pkg.sv
// rib_pkg: shared constants for the RIB crossbar
package rib_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int SEL_HI = 31;
  localparam int SEL_LO = 28;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
endpackage

// File: rtl/rib_arbiter.sv
// rib_arbiter: registered bus ownership with fixed/round-robin selection, parking and hold limiting
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int PARK_MASTER = 1,
  parameter int MAX_HOLD = 16,
  parameter int OW = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req_i,
  output logic [OW-1:0]          owner_o
);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [OW-1:0] PARK = OW'(PARK_MASTER);
  logic [OW-1:0] owner_q, rr_ptr_q, win_fix, win_rr, win, owner_d;
  logic [HW-1:0] hold_cnt_q;
  logic contend, rearb;
  // lowest-index requester and first requester after rr_ptr_q, both falling back to the park master
  always_comb begin
    win_fix = PARK;
    win_rr = PARK;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      win_fix = m_req_i[OW'(i)] ? OW'(i) : win_fix;
    for (int i = NUM_MASTERS; i >= 1; i--)
      win_rr = m_req_i[OW'((int'(rr_ptr_q) + i) % NUM_MASTERS)] ? OW'((int'(rr_ptr_q) + i) % NUM_MASTERS) : win_rr;
  end
  assign contend = |(m_req_i & ~(NUM_MASTERS'(1) << owner_q));
  assign rearb = !m_req_i[owner_q] || (ARB_MODE == ARB_RR && hold_cnt_q == HW'(MAX_HOLD - 1) && contend);
  assign win = (ARB_MODE == ARB_RR) ? win_rr : win_fix;
  assign owner_d = rearb ? win : owner_q;
  assign owner_o = owner_q;
  // owner, round-robin pointer and saturating consecutive-hold counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner_q <= PARK;
      rr_ptr_q <= PARK;
      hold_cnt_q <= '0;
    end else begin
      owner_q <= owner_d;
      rr_ptr_q <= (rearb && |m_req_i) ? win : rr_ptr_q;
      hold_cnt_q <= (!m_req_i[owner_q] || owner_d != owner_q) ? '0 :
                    (hold_cnt_q == HW'(MAX_HOLD - 1)) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
endmodule

// File: rtl/rib_xbar.sv
// rib_xbar: N-master to M-slave shared bus with address decode and sticky unmapped-access record
module rib_xbar
  import rib_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES = 6,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int PARK_MASTER = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_data_i,
  input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
  output logic [NUM_MASTERS*DW-1:0] m_data_o,
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      hold_flag_o,
  output logic [AW-1:0]             s_addr_o,
  output logic [DW-1:0]             s_data_o,
  output logic [SW-1:0]             s_sel_o,
  output logic [NUM_SLAVES-1:0]     s_we_o,
  input  logic [NUM_SLAVES*DW-1:0]  s_data_i,
  output logic                      err_valid_o,
  output logic [AW-1:0]             err_addr_o,
  input  logic                      err_clr_i
);
  localparam int OW = $clog2(NUM_MASTERS);
  logic [OW-1:0] owner;
  logic [AW-1:0] m_addr [NUM_MASTERS];
  logic [DW-1:0] m_wdata [NUM_MASTERS];
  logic [SW-1:0] m_sel [NUM_MASTERS];
  logic [DW-1:0] s_rdata [16];
  logic [AW-1:0] o_addr, err_addr_q;
  logic [3:0] idx;
  logic o_req, o_we, mapped, err, err_valid_q;

  rib_arbiter #(
    .NUM_MASTERS(NUM_MASTERS),
    .ARB_MODE(ARB_MODE),
    .PARK_MASTER(PARK_MASTER),
    .MAX_HOLD(MAX_HOLD)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .m_req_i(m_req_i),
    .owner_o(owner)
  );

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_m
    assign m_addr[k] = m_addr_i[AW*k +: AW];
    assign m_wdata[k] = m_data_i[DW*k +: DW];
    assign m_sel[k] = m_sel_i[SW*k +: SW];
  end

  for (genvar i = 0; i < 16; i++) begin : g_s
    if (i < NUM_SLAVES) begin : g_map
      assign s_rdata[i] = s_data_i[DW*i +: DW];
    end else begin : g_unmap
      assign s_rdata[i] = '0;
    end
  end

  assign o_addr = m_addr[owner];
  assign o_req = rst & m_req_i[owner];
  assign o_we = m_we_i[owner];
  assign idx = o_addr[SEL_HI:SEL_LO];
  assign mapped = {1'b0, idx} < 5'(NUM_SLAVES);
  assign err = o_req & ~mapped;
  assign s_addr_o = {4'h0, o_addr[SEL_LO-1:0]};
  assign s_data_o = m_wdata[owner];
  assign s_sel_o = m_sel[owner];
  assign s_we_o = (o_req && o_we && mapped) ? NUM_SLAVES'(1) << idx : '0;
  assign m_data_o = (rst && mapped) ? (NUM_MASTERS*DW)'(s_rdata[idx]) << (DW * owner) : '0;
  assign m_err_o = err ? NUM_MASTERS'(1) << owner : '0;
  assign m_gnt_o = NUM_MASTERS'(1) << owner;
  assign hold_flag_o = rst & |(m_req_i & ~m_gnt_o);
  assign err_valid_o = err_valid_q;
  assign err_addr_o = err_addr_q;

  // sticky record of the first unmapped access; a clear coinciding with a new error re-arms on that error
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      err_valid_q <= 1'b0;
      err_addr_q <= '0;
    end else if (err && (!err_valid_q || err_clr_i)) begin
      err_valid_q <= 1'b1;
      err_addr_q <= o_addr;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_rib_xbar.sv
// tb_rib_xbar: directed checks of a fixed-priority and a round-robin crossbar instance
module tb_rib_xbar;
  logic clk = 0, rst = 0, err_clr = 0;
  logic [3:0] req = '0, we = '0;
  logic [127:0] addr = '0, wdata = '0;
  logic [15:0] sel = '0;
  logic [191:0] sdata;
  logic [127:0] f_rd, r_rd;
  logic [3:0] f_gnt, r_gnt, f_err, r_err;
  logic f_hold, r_hold, f_ev, r_ev;
  logic [31:0] f_saddr, r_saddr, f_sdata, r_sdata, f_eaddr, r_eaddr;
  logic [3:0] f_ssel, r_ssel;
  logic [5:0] f_swe, r_swe;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  rib_xbar u_fix (
    .clk(clk), .rst(rst), .m_req_i(req), .m_we_i(we), .m_addr_i(addr), .m_data_i(wdata),
    .m_sel_i(sel), .m_data_o(f_rd), .m_gnt_o(f_gnt), .m_err_o(f_err), .hold_flag_o(f_hold),
    .s_addr_o(f_saddr), .s_data_o(f_sdata), .s_sel_o(f_ssel), .s_we_o(f_swe), .s_data_i(sdata),
    .err_valid_o(f_ev), .err_addr_o(f_eaddr), .err_clr_i(err_clr)
  );

  rib_xbar #(.ARB_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .m_req_i(req), .m_we_i(we), .m_addr_i(addr), .m_data_i(wdata),
    .m_sel_i(sel), .m_data_o(r_rd), .m_gnt_o(r_gnt), .m_err_o(r_err), .hold_flag_o(r_hold),
    .s_addr_o(r_saddr), .s_data_o(r_sdata), .s_sel_o(r_ssel), .s_we_o(r_swe), .s_data_i(sdata),
    .err_valid_o(r_ev), .err_addr_o(r_eaddr), .err_clr_i(err_clr)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req[k] = r;
    we[k] = w;
    addr[32*k +: 32] = a;
    wdata[32*k +: 32] = d;
    sel[4*k +: 4] = s;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) sdata[32*i +: 32] = 32'hD000_0000 + i;
    tick();
    tick();
    chk("rst_gnt", f_gnt, 4'b0010);
    chk("rst_we", f_swe, 6'b0);
    chk("rst_hold", f_hold, 1'b0);
    chk("rst_rd", f_rd, 128'h0);
    chk("rr_rst_gnt", r_gnt, 4'b0010);
    rst = 1;
    tick();
    chk("idle_gnt", f_gnt, 4'b0010);
    chk("idle_hold", f_hold, 1'b0);
    set_m(1, 1, 0, 32'h1000_0004, 32'h0, 4'hF);
    #1;
    chk("rd_saddr", f_saddr, 32'h0000_0004);
    chk("rd_data", f_rd, {64'h0, 32'hD000_0001, 32'h0});
    chk("rd_gnt", f_gnt, 4'b0010);
    chk("rd_we", f_swe, 6'b0);
    tick();
    set_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
    set_m(0, 1, 0, 32'h0, 32'h0, 4'hF);
    set_m(3, 1, 0, 32'h0, 32'h0, 4'hF);
    #1;
    chk("fp_wait_gnt", f_gnt, 4'b0010);
    chk("fp_wait_hold", f_hold, 1'b1);
    tick();
    chk("fp_gnt0", f_gnt, 4'b0001);
    chk("fp_hold", f_hold, 1'b1);
    tick();
    chk("fp_keep", f_gnt, 4'b0001);
    set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("fp_drop_gnt", f_gnt, 4'b0001);
    tick();
    chk("fp_gnt3", f_gnt, 4'b1000);
    chk("fp_hold_clr", f_hold, 1'b0);
    set_m(3, 1, 1, 32'h2000_0010, 32'hCAFE_F00D, 4'b0011);
    #1;
    chk("wr_we", f_swe, 6'b000100);
    chk("wr_sel", f_ssel, 4'b0011);
    chk("wr_data", f_sdata, 32'hCAFE_F00D);
    chk("wr_saddr", f_saddr, 32'h0000_0010);
    chk("wr_rd", f_rd, {32'hD000_0002, 96'h0});
    chk("wr_err", f_err, 4'b0);
    tick();
    set_m(3, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("park_gnt", f_gnt, 4'b0010);
    set_m(0, 1, 0, 32'h7000_0000, 32'h0, 4'hF);
    tick();
    #1;
    chk("ue_err", f_err, 4'b0001);
    chk("ue_rd", f_rd, 128'h0);
    chk("ue_we", f_swe, 6'b0);
    chk("ue_ev_pre", f_ev, 1'b0);
    tick();
    chk("ue_ev", f_ev, 1'b1);
    chk("ue_addr", f_eaddr, 32'h7000_0000);
    set_m(0, 1, 0, 32'h8000_0000, 32'h0, 4'hF);
    #1;
    chk("ue2_err", f_err, 4'b0001);
    tick();
    chk("ue2_addr", f_eaddr, 32'h7000_0000);
    chk("ue2_ev", f_ev, 1'b1);
    set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr_ev", f_ev, 1'b0);
    set_m(0, 1, 0, 32'h9000_0000, 32'h0, 4'hF);
    tick();
    tick();
    chk("ue3_ev", f_ev, 1'b1);
    chk("ue3_addr", f_eaddr, 32'h9000_0000);
    set_m(0, 1, 0, 32'hA000_0000, 32'h0, 4'hF);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr_new_ev", f_ev, 1'b1);
    chk("clr_new_addr", f_eaddr, 32'hA000_0000);
    set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    set_m(0, 1, 1, 32'h1000_0000, 32'h1234_5678, 4'hF);
    tick();
    chk("rm_we", f_swe, 6'b000010);
    #2;
    rst = 0;
    #1;
    chk("rm_we_async", f_swe, 6'b0);
    chk("rm_gnt_async", f_gnt, 4'b0010);
    chk("rm_hold", f_hold, 1'b0);
    chk("rm_rd", f_rd, 128'h0);
    chk("rm_ev", f_ev, 1'b0);
    tick();
    #2;
    rst = 1;
    #1;
    chk("rm_park", f_gnt, 4'b0010);
    tick();
    chk("rm_regain", f_gnt, 4'b0001);
    set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
    rst = 0;
    tick();
    rst = 1;
    set_m(0, 1, 0, 32'h0, 32'h0, 4'hF);
    set_m(2, 1, 0, 32'h0, 32'h0, 4'hF);
    set_m(3, 1, 0, 32'h0, 32'h0, 4'hF);
    #1;
    chk("rr_start", r_gnt, 4'b0010);
    for (int i = 0; i < 13; i++) begin
      logic [3:0] e;
      tick();
      e = (i < 4) ? 4'b0100 : (i < 8) ? 4'b1000 : (i < 12) ? 4'b0001 : 4'b0100;
      chk($sformatf("rr_gnt%0d", i), r_gnt, e);
    end
    chk("rr_hold", r_hold, 1'b1);
    chk("fp_no_rot", f_gnt, 4'b0001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rib_xbar.md
Name: rib_xbar

Overview:
- Parametrised successor to the fixed 4-master/6-slave RIB interconnect.
- N masters share one bus to M slaves. Slave decode uses addr[31:28].
- Bus ownership is registered, with two selectable arbitration modes, a parked default master, and anti-starvation hold limiting.
- Unmapped accesses produce an error response and are captured in a sticky error record.

Parameters:
- NUM_MASTERS, 4, number of masters (2..8).
- NUM_SLAVES, 6, number of slaves (1..16); slave i occupies region addr[31:28]==i.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- PARK_MASTER, 1, master granted while the bus is idle and out of reset (core fetch port).
- MAX_HOLD, 16, round-robin only: maximum consecutive owned cycles while another master waits (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- m_req_i  in  NUM_MASTERS  per-master request
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_addr_i  in  NUM_MASTERS*32  per-master address, master k at [32k+31:32k]
- m_data_i  in  NUM_MASTERS*32  per-master write data
- m_sel_i  in  NUM_MASTERS*4  per-master byte select
- m_data_o  out  NUM_MASTERS*32  read data; zero for non-owners
- m_gnt_o  out  NUM_MASTERS  one-hot current owner
- m_err_o  out  NUM_MASTERS  owner accessed an unmapped region this cycle
- hold_flag_o  out  1  a requesting master is not the owner
- s_addr_o  out  32  {4'h0, owner addr[27:0]}, broadcast
- s_data_o  out  32  owner write data, broadcast
- s_sel_o  out  4  owner byte select, broadcast
- s_we_o  out  NUM_SLAVES  per-slave write strobe
- s_data_i  in  NUM_SLAVES*32  per-slave read data
- err_valid_o  out  1  sticky unmapped-access flag
- err_addr_o  out  32  address of the first captured unmapped access
- err_clr_i  in  1  clears err_valid_o

Behaviour:
- Registered state: owner_q (index), rr_ptr_q, hold_cnt_q, err_valid_q, err_addr_q.
- Reset (rst low, async):
  - owner_q = PARK_MASTER, rr_ptr_q = PARK_MASTER, hold_cnt_q = 0, err_* = 0.
  - Outputs: m_gnt_o = one-hot PARK_MASTER; s_we_o = 0; m_err_o = 0; m_data_o = 0; hold_flag_o = 0.
- Datapath (combinational, from owner_q):
  - Owner addr/data/sel drive the s_* outputs.
  - Decode idx = owner addr[31:28].
  - s_we_o[idx] = owner req & owner we, only when idx < NUM_SLAVES.
  - m_data_o[owner] = s_data_i[idx] when mapped, else 0.
  - Access latency is zero wait states once owned.
- Re-arbitration occurs in a cycle when any of these hold:
  - (a) the owner's m_req_i is low;
  - (b) ARB_MODE=1, hold_cnt_q == MAX_HOLD-1, and another master requests.
- Winner selection:
  - ARB_MODE=0: lowest-index requester.
  - ARB_MODE=1: first requester scanning from rr_ptr_q+1 with wrap; rr_ptr_q is updated to the winner.
  - No requester: winner = PARK_MASTER.
- Timing of ownership changes:
  - The winner is loaded into owner_q at the next edge and is served one cycle after it is chosen.
  - A parked master that requests is therefore served with no wait.
  - A non-parked master waits ≥1 cycle.
  - A master whose req stays high keeps ownership, subject only to rule (b).
- hold_cnt_q:
  - Increments while the owner requests and ownership is unchanged.
  - Resets to 0 on an ownership change or when the owner's req is low.
  - Saturates at MAX_HOLD-1.
- hold_flag_o = |(m_req_i & ~m_gnt_o).
- Unmapped access (owner req & idx >= NUM_SLAVES):
  - No slave strobe; read data 0; m_err_o[owner] = 1 in the same cycle.
  - If err_valid_q = 0, the next edge sets err_valid_q and captures the full 32-bit address. Later errors are ignored while err_valid_q = 1.
  - err_clr_i clears err_valid_q at the next edge. If clr and a new error coincide, the new error is captured and err_valid stays 1.
- Reset mid-access: the access is abandoned immediately; no write strobe is asserted after rst falls.

Decomposition:
- Package rib_pkg:
  - Slave-select field position (31:28).
  - ARB_FIXED=0, ARB_RR=1.
  - Bus widths (32-bit address/data, 4-bit sel).
- Sub-module rib_arbiter:
  - Holds owner_q, rr_ptr_q and hold_cnt_q.
  - Inputs: m_req_i. Output: owner index.
  - The top contains decode, muxing and error capture.

Test Plan:
- Reset release, no requests: m_gnt_o=4'b0010. m1 req read 0x1000_0004: same-cycle s_addr_o=0x0000_0004 and m_data_o[1]=s_data_i[1].
- ARB_MODE=0, m0 and m3 request together while m1 is parked: next cycle m_gnt_o=0001 and hold_flag_o=1. m0 drops req: next cycle m_gnt_o=1000.
- ARB_MODE=1, MAX_HOLD=4, m0/m2/m3 continuously requesting: ownership rotates every 4 cycles in order 2→3→0→2.
- m3 write to 0x2000_0010 with sel=4'b0011: s_we_o=6'b000100, s_sel_o=0011, s_data_o=m3 data. Other s_we_o bits stay 0.
- m0 reads 0x7000_0000 with NUM_SLAVES=6: m_err_o[0]=1, m_data_o=0, no strobe. Next cycle err_valid_o=1 and err_addr_o=0x7000_0000. A second error at 0x8000_0000 leaves err_addr unchanged. err_clr_i clears err_valid_o.
- rst asserted low while m0 holds the bus writing: s_we_o drops to 0 asynchronously. After release, m_gnt_o = parked master.
